branch_predict_unit: RTL

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// Branch predictor: 2-bit saturating pattern table with one-cycle lookup, one-cycle
// resolution/update (write-through bypass to same-cycle lookups) and saturating statistics.
module branch_predict_unit #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_req,
  input  logic [IDX_W-1:0]  pred_idx,
  output logic              pred_valid,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [IDX_W-1:0]  res_idx,
  input  logic [2:0]        res_type,
  input  logic [DATA_W-1:0] res_operand,
  input  logic              res_pred,
  input  logic              flush,
  output logic              out_valid,
  output logic              out_taken,
  output logic              out_mispredict,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  localparam logic [2:0] T_BEQZ = 3'b000;
  localparam logic [2:0] T_BNEZ = 3'b001;
  localparam logic [2:0] T_BLTZ = 3'b010;
  localparam logic [2:0] T_BGEZ = 3'b011;
  localparam logic [2:0] T_JUMP = 3'b100;
  localparam logic [2:0] T_BGTZ = 3'b101;
  localparam logic [2:0] T_BLEZ = 3'b110;

  logic [1:0]        ctr_q [DEPTH];
  logic              pred_valid_q, pred_valid_d;
  logic              pred_taken_q, pred_taken_d;
  logic              out_valid_q, out_valid_d;
  logic              out_taken_q, out_taken_d;
  logic              out_mis_q, out_mis_d;
  logic [STAT_W-1:0] stat_br_q, stat_br_d;
  logic [STAT_W-1:0] stat_mis_q, stat_mis_d;

  logic       res_zero_c, res_sign_c, res_taken_c, res_cond_c, res_branch_c, res_mis_c;
  logic       upd_en_c;
  logic [1:0] cur_ctr_c, upd_ctr_c, look_ctr_c;

  // Resolution decode, counter update and bypassed lookup
  always_comb begin
    res_zero_c   = (res_operand == '0);
    res_sign_c   = res_operand[DATA_W-1];
    res_taken_c  = 1'b0;
    res_cond_c   = 1'b1;
    unique case (res_type)
      T_BEQZ:  res_taken_c = res_zero_c;
      T_BNEZ:  res_taken_c = !res_zero_c;
      T_BLTZ:  res_taken_c = res_sign_c;
      T_BGEZ:  res_taken_c = !res_sign_c;
      T_BGTZ:  res_taken_c = !res_sign_c && !res_zero_c;
      T_BLEZ:  res_taken_c = res_sign_c || res_zero_c;
      T_JUMP: begin
        res_taken_c = 1'b1;
        res_cond_c  = 1'b0;
      end
      default: begin
        res_taken_c = 1'b0;
        res_cond_c  = 1'b0;
      end
    endcase
    res_branch_c = res_valid && (res_type != 3'b111);
    res_mis_c    = res_taken_c != res_pred;
    upd_en_c     = res_valid && res_cond_c;

    cur_ctr_c = ctr_q[res_idx];
    if (res_taken_c) upd_ctr_c = (cur_ctr_c == 2'b11) ? 2'b11 : cur_ctr_c + 2'd1;
    else             upd_ctr_c = (cur_ctr_c == 2'b00) ? 2'b00 : cur_ctr_c - 2'd1;

    look_ctr_c = (upd_en_c && (res_idx == pred_idx)) ? upd_ctr_c : ctr_q[pred_idx];
  end

  // Next-state for registered outputs and statistics
  always_comb begin
    pred_valid_d = pred_req && !flush;
    pred_taken_d = pred_valid_d ? look_ctr_c[1] : 1'b0;
    out_valid_d  = res_branch_c;
    out_taken_d  = res_branch_c ? res_taken_c : 1'b0;
    out_mis_d    = res_branch_c ? res_mis_c : 1'b0;
    stat_br_d    = stat_br_q;
    stat_mis_d   = stat_mis_q;
    if (res_branch_c && (stat_br_q != '1)) stat_br_d = stat_br_q + STAT_W'(1);
    if (res_branch_c && res_mis_c && (stat_mis_q != '1)) stat_mis_d = stat_mis_q + STAT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) ctr_q[i] <= 2'b01;
    end else if (upd_en_c) begin
      ctr_q[res_idx] <= upd_ctr_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_taken_q  <= 1'b0;
      out_mis_q    <= 1'b0;
      stat_br_q    <= '0;
      stat_mis_q   <= '0;
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      out_valid_q  <= out_valid_d;
      out_taken_q  <= out_taken_d;
      out_mis_q    <= out_mis_d;
      stat_br_q    <= stat_br_d;
      stat_mis_q   <= stat_mis_d;
    end
  end

  assign pred_valid       = pred_valid_q;
  assign pred_taken       = pred_taken_q;
  assign out_valid        = out_valid_q;
  assign out_taken        = out_taken_q;
  assign out_mispredict   = out_mis_q;
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;

endmodule
